// File: rtl/wishbone_mem_decoder.sv
// Wishbone single-master to NUM_SLAVES memory interconnect with base/size windows,
// unmapped-address and ack-timeout bus errors, master abort and registered interrupt OR.
module wishbone_mem_decoder #(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {32'h0300_0000, 32'h0200_0000,
                                                     32'h0100_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_SIZE = {4{32'h0100_0000}},
  parameter bit                        LOCAL_ADDR = 1'b1,
  parameter int                        TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_m_we,
  input  logic                         i_m_stb,
  input  logic                         i_m_cyc,
  input  logic [3:0]                   i_m_sel,
  input  logic [31:0]                  i_m_adr,
  input  logic [31:0]                  i_m_dat,
  output logic [31:0]                  o_m_dat,
  output logic                         o_m_ack,
  output logic                         o_m_err,
  output logic                         o_m_int,
  output logic [31:0]                  o_err_adr,
  output logic [NUM_SLAVES-1:0]        o_s_we,
  output logic [NUM_SLAVES-1:0]        o_s_stb,
  output logic [NUM_SLAVES-1:0]        o_s_cyc,
  output logic [3:0]                   o_s_sel,
  output logic [31:0]                  o_s_adr,
  output logic [31:0]                  o_s_dat,
  input  logic [32*NUM_SLAVES-1:0]     i_s_dat,
  input  logic [NUM_SLAVES-1:0]        i_s_ack,
  input  logic [NUM_SLAVES-1:0]        i_s_int
);

  localparam int              IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int              CNT_W    = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR, RELEASE} state_t;

  state_t                  state, state_nxt;
  logic [NUM_SLAVES-1:0]   s_cyc_p0, s_cyc_nxt;
  logic [NUM_SLAVES-1:0]   s_we_p0, s_we_nxt;
  logic [31:0]             s_adr_p0, s_adr_nxt;
  logic [3:0]              s_sel_p0, s_sel_nxt;
  logic [31:0]             s_dat_p0, s_dat_nxt;
  logic [31:0]             m_dat_p0, m_dat_nxt;
  logic                    m_ack_p0, m_ack_nxt;
  logic                    m_err_p0, m_err_nxt;
  logic                    m_int_p0;
  logic [31:0]             err_adr_p0, err_adr_nxt;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0]        idx_p0;
  logic [31:0]             adr_p0;
  logic                    load;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [31:0]             hit_base;

  // 33-bit compare so a window ending at 4 GiB does not wrap to zero.
  function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] top;
    top = {1'b0, base} + {1'b0, size};
    return ({1'b0, adr} >= {1'b0, base}) && ({1'b0, adr} < top);
  endfunction

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SLAVES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (in_window(i_m_adr, SLAVE_BASE[32*k +: 32], SLAVE_SIZE[32*k +: 32])) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(k);
        hit_base = SLAVE_BASE[32*k +: 32];
      end
    end
  end

  assign cnt_inc = cnt_p0 + CNT_W'(1);

  always_comb begin
    state_nxt   = state;
    s_cyc_nxt   = s_cyc_p0;
    s_we_nxt    = s_we_p0;
    s_adr_nxt   = s_adr_p0;
    s_sel_nxt   = s_sel_p0;
    s_dat_nxt   = s_dat_p0;
    m_dat_nxt   = m_dat_p0;
    m_ack_nxt   = 1'b0;
    m_err_nxt   = 1'b0;
    err_adr_nxt = err_adr_p0;
    cnt_nxt     = cnt_p0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (i_m_cyc && i_m_stb) begin
          if (hit) begin
            load      = 1'b1;
            s_cyc_nxt = onehot(hit_idx);
            s_we_nxt  = i_m_we ? onehot(hit_idx) : '0;
            s_adr_nxt = LOCAL_ADDR ? (i_m_adr - hit_base) : i_m_adr;
            s_sel_nxt = i_m_sel;
            s_dat_nxt = i_m_dat;
            cnt_nxt   = '0;
            state_nxt = ACTIVE;
          end else begin
            err_adr_nxt = i_m_adr;
            m_dat_nxt   = '0;
            m_err_nxt   = 1'b1;
            state_nxt   = ERROR;
          end
        end
      end
      ACTIVE: begin
        if (!i_m_cyc) begin
          s_cyc_nxt = '0;
          s_we_nxt  = '0;
          state_nxt = IDLE;
        end else if (|(i_s_ack & s_cyc_p0)) begin
          m_dat_nxt = i_s_dat[{idx_p0, 5'd0} +: 32];
          m_ack_nxt = 1'b1;
          s_cyc_nxt = '0;
          s_we_nxt  = '0;
          state_nxt = RELEASE;
        end else if (TO_EN && (cnt_inc == TO_LIMIT)) begin
          m_err_nxt   = 1'b1;
          err_adr_nxt = adr_p0;
          s_cyc_nxt   = '0;
          s_we_nxt    = '0;
          state_nxt   = RELEASE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ERROR:   state_nxt = RELEASE;
      RELEASE: if (!i_m_stb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stage p0: control and registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      s_cyc_p0   <= '0;
      s_we_p0    <= '0;
      s_adr_p0   <= '0;
      s_sel_p0   <= '0;
      s_dat_p0   <= '0;
      m_dat_p0   <= '0;
      m_ack_p0   <= 1'b0;
      m_err_p0   <= 1'b0;
      m_int_p0   <= 1'b0;
      err_adr_p0 <= '0;
      cnt_p0     <= '0;
    end else begin
      state      <= state_nxt;
      s_cyc_p0   <= s_cyc_nxt;
      s_we_p0    <= s_we_nxt;
      s_adr_p0   <= s_adr_nxt;
      s_sel_p0   <= s_sel_nxt;
      s_dat_p0   <= s_dat_nxt;
      m_dat_p0   <= m_dat_nxt;
      m_ack_p0   <= m_ack_nxt;
      m_err_p0   <= m_err_nxt;
      m_int_p0   <= |i_s_int;
      err_adr_p0 <= err_adr_nxt;
      cnt_p0     <= cnt_nxt;
    end
  end

  // stage p0: transfer context, only consumed while ACTIVE
  always_ff @(posedge clk) begin
    if (load) begin
      idx_p0 <= hit_idx;
      adr_p0 <= i_m_adr;
    end
  end

  assign o_s_cyc   = s_cyc_p0;
  assign o_s_stb   = s_cyc_p0;
  assign o_s_we    = s_we_p0;
  assign o_s_adr   = s_adr_p0;
  assign o_s_sel   = s_sel_p0;
  assign o_s_dat   = s_dat_p0;
  assign o_m_dat   = m_dat_p0;
  assign o_m_ack   = m_ack_p0;
  assign o_m_err   = m_err_p0;
  assign o_m_int   = m_int_p0;
  assign o_err_adr = err_adr_p0;

endmodule
